// File: rtl/du_pkg.sv
// Shared command bytes and controller state encoding for the debug unit.
package du_pkg;

    localparam logic [7:0] CMD_STEP_MODE = 8'h0F;
    localparam logic [7:0] CMD_CONT_MODE = 8'hF0;
    localparam logic [7:0] CMD_STEP      = 8'h0A;
    localparam logic [7:0] CMD_EXIT      = 8'h0B;
    localparam logic [7:0] RSP_ERROR     = 8'hEE;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MODE,
        STEP_WAIT,
        STEP_RUN,
        RUN,
        DUMP,
        ERROR
    } du_state_t;

endpackage

// File: rtl/du_tx_serializer.sv
// Streams a captured snapshot LSB byte first, one byte per tx_done handshake.
// DU_CHECKSUM_EN appends the XOR of all snapshot bytes as a final byte.
module du_tx_serializer #(
    parameter int N_DUMP_BYTES = 140,
    parameter int NB_SEND      = 8*N_DUMP_BYTES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NB_SEND-1:0] snapshot,
    input  logic               tx_done_i,
    output logic [7:0]         tx_data_o,
    output logic               tx_start_o,
    output logic               done
);

`ifdef DU_CHECKSUM_EN
    localparam int N_TX = N_DUMP_BYTES + 1;
`else
    localparam int N_TX = N_DUMP_BYTES;
`endif
    localparam int IW = $clog2(N_TX);

    logic [N_DUMP_BYTES-1:0][7:0] snap;
    logic [IW-1:0]                idx;
    logic                         busy;
    logic                         issue;
    logic                         last;

    assign last       = (idx == IW'(N_TX - 1));
    assign tx_start_o = issue;
    assign done       = busy & ~issue & tx_done_i & last;

`ifdef DU_CHECKSUM_EN
    logic [7:0] csum;

    assign tx_data_o = (idx == IW'(N_DUMP_BYTES)) ? csum : snap[idx];

    // Accumulated as each data byte is launched, so it is complete by the extra slot.
    always_ff @(posedge clk) begin
        if (rst || (start && !busy)) begin
            csum <= 8'h00;
        end else if (issue && (idx != IW'(N_DUMP_BYTES))) begin
            csum <= csum ^ snap[idx];
        end
    end
`else
    assign tx_data_o = snap[idx];
`endif

    // issue is high for exactly the one cycle tx_start_o pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap  <= '0;
            idx   <= '0;
            busy  <= 1'b0;
            issue <= 1'b0;
        end else if (start && !busy) begin
            snap  <= snapshot;
            idx   <= '0;
            busy  <= 1'b1;
            issue <= 1'b1;
        end else if (busy) begin
            if (issue) begin
                issue <= 1'b0;
            end else if (tx_done_i) begin
                if (last) begin
                    busy <= 1'b0;
                end else begin
                    idx   <= idx + 1'b1;
                    issue <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/debug_unit_ctrl.sv
// UART-driven debug controller: program load, step/continue run, state dump.
// Optional DU_CHECKSUM_EN adds an XOR checksum byte after every dump.
module debug_unit_ctrl
    import du_pkg::*;
#(
    parameter int NB_DATA      = 32,
    parameter int N_BYTES      = NB_DATA/8,
    parameter int MAX_INST     = 64,
    parameter int N_DUMP_BYTES = 140,
    parameter int NB_SEND      = 8*N_DUMP_BYTES
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic [7:0]         rx_data_i,
    input  logic               rx_done_i,
    output logic [7:0]         tx_data_o,
    output logic               tx_start_o,
    input  logic               tx_done_i,
    input  logic               halt_i,
    input  logic [NB_SEND-1:0] data_send_i,
    output logic               enable_pipe_o,
    output logic               en_write_o,
    output logic [NB_DATA-1:0] address_o,
    output logic [NB_DATA-1:0] inst_load_o,
    output logic               enable_read_reg_o,
    output logic               step_mode_o
);

    localparam int NCW = $clog2(MAX_INST + 1);
    localparam int BCW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    du_state_t                 state, next_state;
    logic [NCW-1:0]            inst_cnt;
    logic [NCW-1:0]            word_idx;
    logic [BCW-1:0]            byte_cnt;
    logic [N_BYTES-1:0][7:0]   word_buf;
    logic [N_BYTES-1:0][7:0]   word_nxt;
    logic                      step_mode;
    logic                      err_sent;
    logic                      cnt_ok;
    logic                      last_byte;
    logic                      last_word;
    logic                      dump_start;
    logic                      ser_done;
    logic                      ser_tx_start;
    logic [7:0]                ser_tx_data;

    assign cnt_ok    = (rx_data_i != 8'h00) && (32'(rx_data_i) <= 32'(MAX_INST));
    assign last_byte = (byte_cnt == BCW'(N_BYTES - 1));
    assign last_word = (word_idx == (inst_cnt - NCW'(1)));

    always_comb begin
        word_nxt           = word_buf;
        word_nxt[byte_cnt] = rx_data_i;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        dump_start = 1'b0;
        case (state)
            IDLE:      if (rx_done_i) next_state = cnt_ok ? LOAD : ERROR;
            // Leave only after the final write strobe has been seen.
            LOAD:      if (en_write_o && last_word) next_state = MODE;
            MODE: begin
                if (rx_done_i) begin
                    if (rx_data_i == CMD_STEP_MODE)      next_state = STEP_WAIT;
                    else if (rx_data_i == CMD_CONT_MODE) next_state = RUN;
                    else                                 next_state = ERROR;
                end
            end
            STEP_WAIT: begin
                if (rx_done_i && rx_data_i == CMD_STEP)      next_state = STEP_RUN;
                else if (rx_done_i && rx_data_i == CMD_EXIT) next_state = IDLE;
            end
            STEP_RUN: begin
                next_state = DUMP;
                dump_start = 1'b1;
            end
            RUN: begin
                if (halt_i) begin
                    next_state = DUMP;
                    dump_start = 1'b1;
                end
            end
            DUMP:      if (ser_done) next_state = step_mode ? STEP_WAIT : IDLE;
            ERROR:     if (err_sent && tx_done_i) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            inst_cnt    <= '0;
            word_idx    <= '0;
            byte_cnt    <= '0;
            word_buf    <= '0;
            en_write_o  <= 1'b0;
            address_o   <= '0;
            inst_load_o <= '0;
            step_mode   <= 1'b0;
            err_sent    <= 1'b0;
        end else begin
            en_write_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_done_i && cnt_ok) begin
                        inst_cnt <= NCW'(rx_data_i);
                        word_idx <= '0;
                        byte_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (rx_done_i) begin
                        word_buf <= word_nxt;
                        if (last_byte) begin
                            byte_cnt    <= '0;
                            en_write_o  <= 1'b1;
                            inst_load_o <= word_nxt;
                            address_o   <= NB_DATA'(word_idx) << 2;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                    if (en_write_o) word_idx <= word_idx + 1'b1;
                end
                MODE:      if (rx_done_i && rx_data_i == CMD_STEP_MODE) step_mode <= 1'b1;
                STEP_WAIT: if (rx_done_i && rx_data_i == CMD_EXIT) step_mode <= 1'b0;
                ERROR: begin
                    if (!err_sent)      err_sent <= 1'b1;
                    else if (tx_done_i) err_sent <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    du_tx_serializer #(
        .N_DUMP_BYTES (N_DUMP_BYTES),
        .NB_SEND      (NB_SEND)
    ) u_tx_ser (
        .clk        (clock_i),
        .rst        (reset_i),
        .start      (dump_start),
        .snapshot   (data_send_i),
        .tx_done_i  (tx_done_i),
        .tx_data_o  (ser_tx_data),
        .tx_start_o (ser_tx_start),
        .done       (ser_done)
    );

    assign enable_pipe_o     = (state == STEP_RUN) || (state == RUN);
    assign enable_read_reg_o = (state == DUMP);
    assign step_mode_o       = step_mode;
    assign tx_start_o        = ser_tx_start | ((state == ERROR) && !err_sent);
    assign tx_data_o         = (state == ERROR) ? RSP_ERROR : ser_tx_data;

endmodule

// File: tb/tb_debug_unit_ctrl.sv
// Directed self-checking bench for debug_unit_ctrl (follows DU_CHECKSUM_EN when defined).
module tb_debug_unit_ctrl;

    localparam int NB_DATA      = 32;
    localparam int N_BYTES      = NB_DATA/8;
    localparam int MAX_INST     = 64;
    localparam int N_DUMP_BYTES = 140;
    localparam int NB_SEND      = 8*N_DUMP_BYTES;
`ifdef DU_CHECKSUM_EN
    localparam int DUMP_LEN = N_DUMP_BYTES + 1;
`else
    localparam int DUMP_LEN = N_DUMP_BYTES;
`endif

    logic               clock_i = 1'b0;
    logic               reset_i;
    logic [7:0]         rx_data_i;
    logic               rx_done_i;
    logic [7:0]         tx_data_o;
    logic               tx_start_o;
    logic               tx_done_i;
    logic               halt_i;
    logic [NB_SEND-1:0] data_send_i;
    logic               enable_pipe_o;
    logic               en_write_o;
    logic [NB_DATA-1:0] address_o;
    logic [NB_DATA-1:0] inst_load_o;
    logic               enable_read_reg_o;
    logic               step_mode_o;

    debug_unit_ctrl #(
        .NB_DATA      (NB_DATA),
        .N_BYTES      (N_BYTES),
        .MAX_INST     (MAX_INST),
        .N_DUMP_BYTES (N_DUMP_BYTES),
        .NB_SEND      (NB_SEND)
    ) dut (
        .clock_i           (clock_i),
        .reset_i           (reset_i),
        .rx_data_i         (rx_data_i),
        .rx_done_i         (rx_done_i),
        .tx_data_o         (tx_data_o),
        .tx_start_o        (tx_start_o),
        .tx_done_i         (tx_done_i),
        .halt_i            (halt_i),
        .data_send_i       (data_send_i),
        .enable_pipe_o     (enable_pipe_o),
        .en_write_o        (en_write_o),
        .address_o         (address_o),
        .inst_load_o       (inst_load_o),
        .enable_read_reg_o (enable_read_reg_o),
        .step_mode_o       (step_mode_o)
    );

    always #5 clock_i = ~clock_i;

    int n_checks  = 0;
    int n_errors  = 0;
    int pipe_cnt  = 0;
    int dbl_start = 0;
    bit tx_busy   = 1'b0;
    logic [7:0]         tx_q[$];
    logic [NB_DATA-1:0] wr_addr_q[$];
    logic [NB_DATA-1:0] wr_data_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observer: records writes, tx bytes and pipeline-enable cycles mid-cycle.
    always @(negedge clock_i) begin
        if (reset_i) begin
            tx_busy = 1'b0;
        end else begin
            if (en_write_o) begin
                wr_addr_q.push_back(address_o);
                wr_data_q.push_back(inst_load_o);
            end
            if (tx_start_o) begin
                if (tx_busy) dbl_start++;
                tx_busy = 1'b1;
                tx_q.push_back(tx_data_o);
            end
            if (tx_done_i) tx_busy = 1'b0;
            if (enable_pipe_o) pipe_cnt++;
        end
    end

    // UART transmitter model: finishes each byte a couple of cycles after tx_start.
    initial begin
        tx_done_i = 1'b0;
        forever begin
            @(negedge clock_i);
            if (tx_start_o === 1'b1) begin
                repeat (2) @(posedge clock_i);
                #1 tx_done_i = 1'b1;
                @(posedge clock_i);
                #1 tx_done_i = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock_i);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clock_i);
        #1 rx_data_i = b;
        rx_done_i = 1'b1;
        @(posedge clock_i);
        #1 rx_done_i = 1'b0;
        tick(3);
    endtask

    task automatic wait_tx(input int n, input int budget);
        int c = 0;
        while (tx_q.size() < n && c < budget) begin
            tick(1);
            c++;
        end
        if (tx_q.size() < n) check("tx_wait_timeout", 64'(tx_q.size()), 64'(n));
        tick(8);
    endtask

    function automatic logic [NB_SEND-1:0] make_snap(input bit onehot, input logic [7:0] seed);
        logic [NB_SEND-1:0] v;
        v = '0;
        for (int k = 0; k < N_DUMP_BYTES; k++)
            v[8*k +: 8] = onehot ? (8'h01 << (k % 8)) : (8'(k) ^ seed);
        return v;
    endfunction

    task automatic check_dump(input string tag, input logic [NB_SEND-1:0] v);
        int bad = 0;
        logic [7:0] x = 8'h00;
        check({tag, "_len"}, 64'(tx_q.size()), 64'(DUMP_LEN));
        for (int k = 0; k < N_DUMP_BYTES && k < tx_q.size(); k++) begin
            if (tx_q[k] !== v[8*k +: 8]) bad++;
            x = x ^ v[8*k +: 8];
        end
        check({tag, "_bytes_wrong"}, 64'(bad), 64'(0));
`ifdef DU_CHECKSUM_EN
        if (tx_q.size() > N_DUMP_BYTES) check({tag, "_csum"}, tx_q[N_DUMP_BYTES], x);
`endif
    endtask

    logic [NB_SEND-1:0] snap;
    int base;
    int run_cnt;
    int c;

    initial begin
        reset_i = 1'b1; rx_data_i = 8'h00; rx_done_i = 1'b0;
        halt_i = 1'b0; data_send_i = '0;
        tick(3);
        check("rst_ctl", {tx_start_o, enable_pipe_o, en_write_o, enable_read_reg_o, step_mode_o, tx_data_o}, 0);
        check("rst_addr", address_o, 0);
        check("rst_inst", inst_load_o, 0);
        reset_i = 1'b0;
        tick(2);

        // Count byte out of range at both ends: one 0xEE each, back to IDLE.
        send_byte(8'h00);
        wait_tx(1, 100);
        send_byte(8'(MAX_INST + 1));
        wait_tx(2, 100);
        check("badcnt_tx_n", 64'(tx_q.size()), 2);
        check("badcnt_rsp0", tx_q[0], 8'hEE);
        check("badcnt_rsp1", tx_q[1], 8'hEE);
        check("badcnt_no_wr", 64'(wr_addr_q.size()), 0);

        // Reset in the middle of a 4-word load.
        send_byte(8'd4);
        for (int i = 0; i < 6; i++) send_byte(8'h10 + 8'(i));
        check("midload_wr_n", 64'(wr_addr_q.size()), 1);
        check("midload_wr0", wr_data_q[0], 32'h13121110);
        @(posedge clock_i);
        #1 reset_i = 1'b1;
        tick(1);
        check("midrst_ctl", {tx_start_o, enable_pipe_o, en_write_o, enable_read_reg_o, step_mode_o, tx_data_o}, 0);
        check("midrst_addr_inst", {address_o, inst_load_o}, 0);
        reset_i = 1'b0;
        tick(2);

        wr_addr_q.delete(); wr_data_q.delete(); tx_q.delete();
        send_byte(8'd2);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        check("load_wr_n", 64'(wr_addr_q.size()), 2);
        check("load_addr0", wr_addr_q[0], 32'h0);
        check("load_inst0", wr_data_q[0], 32'h12345678);
        check("load_addr1", wr_addr_q[1], 32'h4);
        check("load_inst1", wr_data_q[1], 32'hDEADBEEF);

        // Step mode: two single steps, each followed by a full dump.
        send_byte(8'h0F);
        check("step_mode_on", step_mode_o, 1);
        for (int s = 0; s < 2; s++) begin
            snap = make_snap(1'b0, (s == 0) ? 8'hA5 : 8'h3C);
            data_send_i = snap;
            tx_q.delete();
            base = pipe_cnt;
            send_byte(8'h0A);
            wait_tx(1, 100);
            data_send_i = ~snap;
            wait_tx(DUMP_LEN, 3000);
            check($sformatf("step%0d_pipe", s), 64'(pipe_cnt - base), 1);
            check_dump($sformatf("step%0d", s), snap);
            check($sformatf("step%0d_rdreg_off", s), enable_read_reg_o, 0);
            check($sformatf("step%0d_mode_hold", s), step_mode_o, 1);
        end
        send_byte(8'h0B);
        check("step_mode_off", step_mode_o, 0);

        // Continue mode: halt on the 50th enabled cycle, rx byte injected mid-dump.
        wr_addr_q.delete(); wr_data_q.delete(); tx_q.delete();
        send_byte(8'd1);
        send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
        check("cont_load_inst", wr_data_q[0], 32'h11223344);
        snap = make_snap(1'b1, 8'h00);
        data_send_i = snap;
        base = pipe_cnt;
        @(posedge clock_i);
        #1 rx_data_i = 8'hF0;
        rx_done_i = 1'b1;
        @(posedge clock_i);
        #1 rx_done_i = 1'b0;
        run_cnt = 0;
        c = 0;
        while (run_cnt < 50 && c < 500) begin
            @(negedge clock_i);
            c++;
            if (enable_pipe_o) run_cnt++;
        end
        halt_i = 1'b1;
        if (run_cnt < 50) check("run_enable_timeout", 64'(run_cnt), 50);
        @(posedge clock_i);
        #1 halt_i = 1'b0;
        check("run_pipe_off_after_halt", enable_pipe_o, 0);
        wait_tx(5, 200);
        data_send_i = '0;
        send_byte(8'h03);
        wait_tx(DUMP_LEN, 3000);
        check("run_pipe_cycles", 64'(pipe_cnt - base), 50);
        check_dump("run", snap);
        check("run_step_mode", step_mode_o, 0);
        check("run_inject_no_wr", 64'(wr_addr_q.size()), 1);

        // Back in IDLE: a zero count must be answered with the error byte.
        tx_q.delete();
        send_byte(8'h00);
        wait_tx(1, 100);
        check("post_run_tx_n", 64'(tx_q.size()), 1);
        check("post_run_idle_err", tx_q[0], 8'hEE);
        check("tx_start_overlap", 64'(dbl_start), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
